perf_counter_bank: RTL and testbench

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_counter_bank.sv | 175 +++++++++++++++++
 tb/tb_perf_counter_bank.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// MMIO bank of performance counters: event, cycle or microsecond counting,
// with compare match, overflow status and a shared high-word read shadow.
module perf_counter_bank #(
   parameter int NUM_CNT        = 4,
   parameter int CNT_WIDTH      = 64,
   parameter int CPU_CLOCK_FREQ = 50_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [11:0]        addr,
   input  logic [31:0]        wdata,
   input  logic               we,
   input  logic               re,
   output logic [31:0]        rdata,
   input  logic [NUM_CNT-1:0] event_in,
   output logic               irq
);

   localparam int HI_W  = CNT_WIDTH - 32;
   localparam int PRESC = CPU_CLOCK_FREQ / 1_000_000;
   localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

   localparam logic [2:0] R_CTRL   = 3'd0;
   localparam logic [2:0] R_STATUS = 3'd1;
   localparam logic [2:0] R_CNT_LO = 3'd2;
   localparam logic [2:0] R_CNT_HI = 3'd3;
   localparam logic [2:0] R_CMP_LO = 3'd4;
   localparam logic [2:0] R_CMP_HI = 3'd5;

   logic [5:0]    ch_sel;
   logic [2:0]    reg_sel;
   logic          ch_hit;
   logic          glb_hit;
   logic          glb_clr;
   logic          unused_addr;
   logic [PW-1:0] presc;
   logic          us_tick;
   logic [HI_W-1:0] shadow;
   logic [31:0]     rd_val;

   logic [NUM_CNT-1:0][4:0]           ctrl_all;
   logic [NUM_CNT-1:0][1:0]           status_all;
   logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt_all;
   logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cmp_all;
   logic [NUM_CNT-1:0]                irq_vec;

   logic [4:0]           sel_ctrl;
   logic [1:0]           sel_status;
   logic [CNT_WIDTH-1:0] sel_cnt;
   logic [CNT_WIDTH-1:0] sel_cmp;

   // Word offsets only; channel i occupies 0x20*i, global register at 0x800.
   assign ch_sel      = addr[10:5];
   assign reg_sel     = addr[4:2];
   assign unused_addr = ^addr[1:0];
   assign glb_hit     = (addr[11:2] == 10'h200);
   assign ch_hit      = !addr[11] && (ch_sel < 6'(NUM_CNT)) && (reg_sel <= R_CMP_HI);
   assign glb_clr     = we && glb_hit;

   // Shared microsecond prescaler, free-running from reset.
   assign us_tick = (presc == PRESC_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n)       presc <= '0;
      else if (us_tick) presc <= '0;
      else              presc <= presc + PW'(1);
   end

   for (genvar i = 0; i < NUM_CNT; i++) begin : g_ch
      logic [4:0]           ctrl_q;
      logic [1:0]           status_q;
      logic [CNT_WIDTH-1:0] cnt_q;
      logic [CNT_WIDTH-1:0] cmp_q;
      logic [CNT_WIDTH-1:0] cnt_inc;
      logic                 sel;
      logic                 wr_lo;
      logic                 wr_hi;
      logic                 wr_st;
      logic                 inc;
      logic                 ovf_set;
      logic                 match_set;

      assign sel   = we && ch_hit && (ch_sel == 6'(i));
      assign wr_lo = sel && (reg_sel == R_CNT_LO);
      assign wr_hi = sel && (reg_sel == R_CNT_HI);
      assign wr_st = sel && (reg_sel == R_STATUS);

      // A software write to either count half displaces this cycle's increment.
      assign inc = ctrl_q[0] && !wr_lo && !wr_hi &&
                   (((ctrl_q[2:1] == 2'd0) && event_in[i]) ||
                     (ctrl_q[2:1] == 2'd1) ||
                    ((ctrl_q[2:1] == 2'd2) && us_tick));

      assign cnt_inc   = cnt_q + CNT_WIDTH'(1);
      assign ovf_set   = inc && (&cnt_q);
      assign match_set = inc && (cnt_inc == cmp_q);

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            ctrl_q   <= '0;
            status_q <= '0;
            cnt_q    <= '0;
            cmp_q    <= '0;
         end else begin
            if (sel && (reg_sel == R_CTRL))   ctrl_q <= wdata[4:0];
            if (sel && (reg_sel == R_CMP_LO)) cmp_q[31:0] <= wdata;
            if (sel && (reg_sel == R_CMP_HI)) cmp_q[CNT_WIDTH-1:32] <= wdata[HI_W-1:0];
            if (glb_clr) begin
               cnt_q    <= '0;
               status_q <= '0;
            end else begin
               if (wr_lo)      cnt_q[31:0] <= wdata;
               else if (wr_hi) cnt_q[CNT_WIDTH-1:32] <= wdata[HI_W-1:0];
               else if (inc)   cnt_q <= (match_set && ctrl_q[4]) ? '0 : cnt_inc;
               // Hardware set is ORed in after the clear so it wins.
               status_q <= (wr_st ? (status_q & ~wdata[1:0]) : status_q) |
                           {ovf_set, match_set};
            end
         end
      end

      assign ctrl_all[i]   = ctrl_q;
      assign status_all[i] = status_q;
      assign cnt_all[i]    = cnt_q;
      assign cmp_all[i]    = cmp_q;
      assign irq_vec[i]    = status_q[0] && ctrl_q[3];
   end

   assign irq = |irq_vec;

   always_comb begin
      sel_ctrl   = '0;
      sel_status = '0;
      sel_cnt    = '0;
      sel_cmp    = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (ch_sel == 6'(i)) begin
            sel_ctrl   = ctrl_all[i];
            sel_status = status_all[i];
            sel_cnt    = cnt_all[i];
            sel_cmp    = cmp_all[i];
         end
      end
   end

   always_comb begin
      rd_val = '0;
      if (glb_hit) begin
         rd_val = {17'd0, 7'(CNT_WIDTH), 2'd0, 6'(NUM_CNT)};
      end else if (ch_hit) begin
         case (reg_sel)
            R_CTRL:   rd_val = 32'(sel_ctrl);
            R_STATUS: rd_val = 32'(sel_status);
            R_CNT_LO: rd_val = sel_cnt[31:0];
            R_CNT_HI: rd_val = 32'(shadow);
            R_CMP_LO: rd_val = sel_cmp[31:0];
            R_CMP_HI: rd_val = 32'(sel_cmp[CNT_WIDTH-1:32]);
            default:  rd_val = '0;
         endcase
      end
   end

   // Registered read port; a CNT_LO read freezes the matching high half.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata  <= '0;
         shadow <= '0;
      end else if (re) begin
         rdata <= rd_val;
         if (ch_hit && (reg_sel == R_CNT_LO)) shadow <= sel_cnt[CNT_WIDTH-1:32];
      end
   end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: register table, directed corner sequences and
// random traffic checked each cycle against a behavioural model.
module tb_perf_counter_bank;

   localparam int NUM = 4;

   logic        clk;
   logic        rst_n;
   logic [11:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic        re;
   logic [31:0] rdata;
   logic [3:0]  event_in;
   logic        irq;

   int n_total = 0;
   int n_bad   = 0;

   perf_counter_bank #(.NUM_CNT(NUM), .CNT_WIDTH(64), .CPU_CLOCK_FREQ(50_000_000)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
      .rdata(rdata), .event_in(event_in), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model state
   longint unsigned m_cnt[NUM];
   longint unsigned m_cmp[NUM];
   bit [4:0]        m_ctrl[NUM];
   bit [1:0]        m_st[NUM];
   longint unsigned m_shadow;
   bit [31:0]       m_rdata;
   int              m_k;

   function automatic bit m_irq();
      bit r = 1'b0;
      for (int i = 0; i < NUM; i++) r |= (m_st[i][0] && m_ctrl[i][3]);
      return r;
   endfunction

   function automatic void model_edge(input bit rst, input bit w, input bit r,
                                      input bit [11:0] a, input bit [31:0] d,
                                      input bit [3:0] ev);
      int ba, ch, off;
      bit glb, valid, tick, cnt_on, swc, fm, fo;
      bit [1:0] ns;
      longint unsigned nc;
      if (rst) begin
         for (int i = 0; i < NUM; i++) begin
            m_cnt[i] = 0; m_cmp[i] = 0; m_ctrl[i] = 0; m_st[i] = 0;
         end
         m_shadow = 0; m_rdata = 0; m_k = 0;
         return;
      end
      ba    = int'(a) & ~3;
      glb   = (ba == 'h800);
      ch    = ba / 32;
      off   = ba % 32;
      valid = (ba < 'h800) && (ch < NUM) && (off <= 'h14);
      m_k++;
      tick  = (m_k % 50 == 0);
      if (r) begin
         m_rdata = 0;
         if (glb) m_rdata = (64 << 8) | NUM;
         else if (valid) begin
            case (off)
               'h00: m_rdata = 32'(m_ctrl[ch]);
               'h04: m_rdata = 32'(m_st[ch]);
               'h08: begin m_rdata = 32'(m_cnt[ch]); m_shadow = m_cnt[ch] >> 32; end
               'h0C: m_rdata = 32'(m_shadow);
               'h10: m_rdata = 32'(m_cmp[ch]);
               'h14: m_rdata = 32'(m_cmp[ch] >> 32);
               default: m_rdata = 0;
            endcase
         end
      end
      for (int i = 0; i < NUM; i++) begin
         swc = w && valid && (ch == i) && (off == 'h08 || off == 'h0C);
         case (m_ctrl[i][2:1])
            2'd0:    cnt_on = ev[i];
            2'd1:    cnt_on = 1'b1;
            2'd2:    cnt_on = tick;
            default: cnt_on = 1'b0;
         endcase
         cnt_on = cnt_on && m_ctrl[i][0] && !swc;
         nc = m_cnt[i]; fm = 0; fo = 0;
         if (cnt_on) begin
            fo = (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF);
            nc = m_cnt[i] + 1;
            if (nc == m_cmp[i]) begin
               fm = 1;
               if (m_ctrl[i][4]) nc = 0;
            end
         end
         if (w && valid && ch == i && off == 'h08) nc = (m_cnt[i] & 64'hFFFF_FFFF_0000_0000) | 64'(d);
         if (w && valid && ch == i && off == 'h0C) nc = (m_cnt[i] & 64'h0000_0000_FFFF_FFFF) | (64'(d) << 32);
         ns = m_st[i];
         if (w && valid && ch == i && off == 'h04) ns = ns & ~d[1:0];
         ns = ns | {fo, fm};
         if (w && glb) begin nc = 0; ns = 0; end
         m_cnt[i] = nc;
         m_st[i]  = ns;
         if (w && valid && ch == i && off == 'h00) m_ctrl[i] = d[4:0];
         if (w && valid && ch == i && off == 'h10) m_cmp[i] = (m_cmp[i] & 64'hFFFF_FFFF_0000_0000) | 64'(d);
         if (w && valid && ch == i && off == 'h14) m_cmp[i] = (m_cmp[i] & 64'h0000_0000_FFFF_FFFF) | (64'(d) << 32);
      end
   endfunction

   function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic void check_rng(input string nm, input logic [31:0] act, input int lo, input int hi);
      n_total++;
      if ($isunknown(act) || act < lo || act > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
      end
   endfunction

   task automatic cycle(input bit rst, input bit w, input bit r, input bit [11:0] a,
                        input bit [31:0] d, input bit [3:0] ev);
      rst_n = !rst; we = w; re = r; addr = a; wdata = d; event_in = ev;
      @(posedge clk);
      model_edge(rst, w, r, a, d, ev);
      #1;
      check("rdata_model", rdata, m_rdata);
      check("irq_model", irq, m_irq());
      rst_n = 1'b1; we = 1'b0; re = 1'b0; event_in = '0;
   endtask

   task automatic wr(input bit [11:0] a, input bit [31:0] d);
      cycle(0, 1, 0, a, d, 0);
   endtask

   task automatic rd(input bit [11:0] a);
      cycle(0, 0, 1, a, 0, 0);
   endtask

   task automatic idle(input int n, input bit [3:0] ev);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, ev);
   endtask

   task automatic do_reset();
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
   endtask

   typedef struct {
      bit        w;
      bit        r;
      bit [11:0] a;
      bit [31:0] d;
      bit        chk;
      bit [31:0] exp;
   } vec_t;

   vec_t vt[$];

   initial begin
      rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; event_in = '0;

      vt.push_back('{1'b1, 1'b0, 12'h800, 32'h0,         1'b0, 32'h0});
      vt.push_back('{1'b0, 1'b1, 12'h800, 32'h0,         1'b1, 32'h0000_4004});
      vt.push_back('{1'b1, 1'b0, 12'h020, 32'hFFFF_FFE6, 1'b0, 32'h0});
      vt.push_back('{1'b0, 1'b1, 12'h020, 32'h0,         1'b1, 32'h0000_0006});
      vt.push_back('{1'b1, 1'b0, 12'h030, 32'hDEAD_BEEF, 1'b0, 32'h0});
      vt.push_back('{1'b0, 1'b1, 12'h030, 32'h0,         1'b1, 32'hDEAD_BEEF});
      vt.push_back('{1'b1, 1'b0, 12'h034, 32'h1234_5678, 1'b0, 32'h0});
      vt.push_back('{1'b0, 1'b1, 12'h034, 32'h0,         1'b1, 32'h1234_5678});
      vt.push_back('{1'b0, 1'b1, 12'h038, 32'h0,         1'b1, 32'h0});
      vt.push_back('{1'b1, 1'b0, 12'h080, 32'hFFFF_FFFF, 1'b0, 32'h0});
      vt.push_back('{1'b0, 1'b1, 12'h080, 32'h0,         1'b1, 32'h0});
      vt.push_back('{1'b0, 1'b1, 12'h804, 32'h0,         1'b1, 32'h0});
      vt.push_back('{1'b1, 1'b0, 12'h028, 32'h0000_0055, 1'b0, 32'h0});
      vt.push_back('{1'b0, 1'b1, 12'h02B, 32'h0,         1'b1, 32'h0000_0055});
      vt.push_back('{1'b1, 1'b1, 12'h030, 32'h0000_0001, 1'b1, 32'hDEAD_BEEF});
      vt.push_back('{1'b0, 1'b1, 12'h030, 32'h0,         1'b1, 32'h0000_0001});
      vt.push_back('{1'b0, 1'b1, 12'h02C, 32'h0,         1'b1, 32'h0});
      vt.push_back('{1'b0, 1'b1, 12'h024, 32'h0,         1'b1, 32'h0});

      // Reset state and register table
      do_reset();
      check("reset_rdata", rdata, 0);
      check("reset_irq", irq, 0);
      foreach (vt[i]) begin
         cycle(0, vt[i].w, vt[i].r, vt[i].a, vt[i].d, 0);
         if (vt[i].chk) check($sformatf("tbl%0d", i), rdata, vt[i].exp);
      end

      // Cycle counting for 100 cycles
      do_reset();
      wr(12'h000, 32'h3);
      idle(100, 0);
      rd(12'h008); check_rng("mode1_lo", rdata, 99, 101);
      rd(12'h00C); check("mode1_hi", rdata, 0);

      // Microsecond counting over 5000 cycles
      do_reset();
      wr(12'h000, 32'h5);
      idle(5000, 0);
      rd(12'h008); check_rng("mode2_lo", rdata, 99, 101);

      // Overflow from preset near all-ones
      do_reset();
      wr(12'h010, 32'h5);
      wr(12'h008, 32'hFFFF_FFFE);
      wr(12'h00C, 32'hFFFF_FFFF);
      wr(12'h000, 32'h3);
      idle(1, 0);
      wr(12'h000, 32'h0);
      rd(12'h008); check("ovf_lo", rdata, 0);
      rd(12'h00C); check("ovf_hi", rdata, 0);
      rd(12'h004); check("ovf_status", rdata, 2);
      wr(12'h004, 32'h2);
      rd(12'h004); check("ovf_w1c", rdata, 0);

      // Shadow holds the pre-carry high word
      do_reset();
      wr(12'h008, 32'hFFFF_FFFF);
      wr(12'h000, 32'h3);
      rd(12'h008); check("shadow_lo", rdata, 32'hFFFF_FFFF);
      rd(12'h00C); check("shadow_hi", rdata, 0);
      wr(12'h000, 32'h0);
      rd(12'h008); check("live_lo", rdata, 2);
      rd(12'h00C); check("live_hi", rdata, 1);

      // Compare match, auto-clear, irq, and set-beats-clear
      do_reset();
      wr(12'h010, 32'd10);
      wr(12'h000, 32'h19);
      idle(10, 4'b0001);
      check("match_irq", irq, 1);
      rd(12'h008); check("autoclr_cnt", rdata, 0);
      idle(9, 4'b0001);
      cycle(0, 1, 0, 12'h004, 32'h1, 4'b0001);
      rd(12'h004); check("set_wins", rdata, 1);
      wr(12'h004, 32'h1);
      rd(12'h004); check("match_cleared", rdata, 0);
      check("irq_cleared", irq, 0);

      // Reset mid-count with irq pending, with a read in flight
      idle(10, 4'b0001);
      check("irq_before_rst", irq, 1);
      cycle(1, 0, 1, 12'h800, 0, 4'b0001);
      check("irq_after_rst", irq, 0);
      check("rdata_after_rst", rdata, 0);
      for (int o = 0; o < 6; o++) begin
         rd(12'(o * 4)); check($sformatf("post_rst_reg%0d", o), rdata, 0);
      end
      rd(12'h800); check("global_id", rdata, 32'h0000_4004);

      // Random traffic against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         bit [11:0] a;
         bit [31:0] d;
         if ($urandom_range(0, 63) == 0) a = 12'h800;
         else a = 12'($urandom_range(0, 4) * 32 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3));
         d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31));
         cycle(($urandom_range(0, 499) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
               a, d, 4'($urandom_range(0, 15)));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
